// File: rtl/bar_smoother_pkg.sv
// Shared sizing, types and FSM encoding for the bar smoother slice.
package bar_smoother_pkg;

    localparam int NUM_BARS    = 16;
    localparam int HEIGHT_W    = 9;
    localparam int MAX_HEIGHT  = 479;
    localparam int DECAY_SHIFT = 3;
    localparam int HOLD_FRAMES = 30;
    localparam int PEAK_FALL   = 2;
    localparam int HOLD_W      = $clog2(HOLD_FRAMES + 1);
    localparam int IDX_W       = $clog2(NUM_BARS);

    typedef logic [HEIGHT_W-1:0] height_t;
    typedef logic [HOLD_W-1:0]   hold_t;

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        PUBLISH
    } state_t;

    localparam height_t MAX_H     = height_t'(MAX_HEIGHT);
    localparam hold_t   HOLD_INIT = hold_t'(HOLD_FRAMES);

    function automatic height_t clamp_height(height_t v);
        return (v > MAX_H) ? MAX_H : v;
    endfunction

endpackage

// File: rtl/bar_smoother_if.sv
// Frame-level bus between load_new_heights, the smoother and VGA_Driver.
interface bar_smoother_if;
    import bar_smoother_pkg::*;

    height_t raw_heights [NUM_BARS];
    logic    raw_valid;
    logic    freeze;
    height_t heights [NUM_BARS];
    height_t peaks [NUM_BARS];
    logic    out_valid;
    logic    busy;
    logic    overrun;

    modport master (
        output raw_heights, raw_valid, freeze,
        input  heights, peaks, out_valid, busy, overrun
    );

    modport slave (
        input  raw_heights, raw_valid, freeze,
        output heights, peaks, out_valid, busy, overrun
    );

endinterface

// File: rtl/bar_update_alu.sv
// Combinational single-bar update: attack/decay of the height, then peak-hold.
module bar_update_alu
    import bar_smoother_pkg::*;
(
    input  height_t raw,
    input  height_t cur,
    input  height_t peak,
    input  hold_t   hold,
    output height_t cur_next,
    output height_t peak_next,
    output hold_t   hold_next
);

    localparam logic [HEIGHT_W:0] ONE_W  = {{HEIGHT_W{1'b0}}, 1'b1};
    localparam logic [HEIGHT_W:0] FALL_W = (HEIGHT_W + 1)'(PEAK_FALL);

    logic [HEIGHT_W:0] decay;
    logic [HEIGHT_W:0] cur_sub;
    logic [HEIGHT_W:0] peak_sub;

    // The extra top bit of each difference is a borrow flag: a borrow means
    // the result would have gone negative and the floor value is used instead.
    always_comb begin
        decay     = {1'b0, cur >> DECAY_SHIFT} + ONE_W;
        cur_sub   = {1'b0, cur} - decay;
        peak_sub  = {1'b0, peak} - FALL_W;
        cur_next  = raw;
        peak_next = peak;
        hold_next = hold;

        if (raw < cur && !cur_sub[HEIGHT_W] && cur_sub[HEIGHT_W-1:0] > raw)
            cur_next = cur_sub[HEIGHT_W-1:0];

        if (cur_next >= peak) begin
            peak_next = cur_next;
            hold_next = HOLD_INIT;
        end else if (hold != '0) begin
            hold_next = hold - 1'b1;
        end else if (peak_sub[HEIGHT_W] || peak_sub[HEIGHT_W-1:0] < cur_next) begin
            peak_next = cur_next;
        end else begin
            peak_next = peak_sub[HEIGHT_W-1:0];
        end
    end

endmodule

// File: rtl/bar_smoother.sv
// Serial per-bar smoother: snapshots a raw frame, updates one bar per clock,
// then publishes heights and peaks together so the display never tears.
module bar_smoother
    import bar_smoother_pkg::*;
(
    input logic           clk,
    input logic           reset_n,
    bar_smoother_if.slave bus
);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    height_t            snap [NUM_BARS];
    height_t            cur [NUM_BARS];
    height_t            pk [NUM_BARS];
    hold_t              hold [NUM_BARS];

    height_t            cur_next;
    height_t            peak_next;
    hold_t              hold_next;

    bar_update_alu u_alu (
        .raw       (snap[idx]),
        .cur       (cur[idx]),
        .peak      (pk[idx]),
        .hold      (hold[idx]),
        .cur_next  (cur_next),
        .peak_next (peak_next),
        .hold_next (hold_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
            for (int i = 0; i < NUM_BARS; i++) begin
                snap[i]        <= '0;
                cur[i]         <= '0;
                pk[i]          <= '0;
                hold[i]        <= '0;
                bus.heights[i] <= '0;
                bus.peaks[i]   <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            // PUBLISH still counts as busy, so only IDLE accepts a frame.
            if (bus.raw_valid && !bus.freeze && state != IDLE)
                bus.overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.raw_valid && !bus.freeze) begin
                        for (int i = 0; i < NUM_BARS; i++)
                            snap[i] <= clamp_height(bus.raw_heights[i]);
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        state    <= PROC;
                    end
                end
                PROC: begin
                    cur[idx]  <= cur_next;
                    pk[idx]   <= peak_next;
                    hold[idx] <= hold_next;
                    if (idx == IDX_W'(NUM_BARS - 1))
                        state <= PUBLISH;
                    else
                        idx <= idx + 1'b1;
                end
                PUBLISH: begin
                    bus.heights   <= cur;
                    bus.peaks     <= pk;
                    bus.out_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_smoother.sv
// Randomised and directed frames against an integer reference of the smoothing rules.
module tb_bar_smoother;
    import bar_smoother_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checkCount = 0;
    int   passCount = 0;

    int   mCur [NUM_BARS];
    int   mPeak [NUM_BARS];
    int   mHold [NUM_BARS];
    int   frame [NUM_BARS];

    bar_smoother_if bus ();

    bar_smoother dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checkCount++;
        if (got == exp)
            passCount++;
        else
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: the smoothing rules applied directly in integer arithmetic.
    function automatic void modelFrame(input int vals [NUM_BARS]);
        for (int i = 0; i < NUM_BARS; i++) begin
            int r;
            r = (vals[i] > MAX_HEIGHT) ? MAX_HEIGHT : vals[i];
            if (r >= mCur[i])
                mCur[i] = r;
            else
                mCur[i] = imax(r, mCur[i] - (mCur[i] / (1 << DECAY_SHIFT) + 1));
            if (mCur[i] >= mPeak[i]) begin
                mPeak[i] = mCur[i];
                mHold[i] = HOLD_FRAMES;
            end else if (mHold[i] > 0) begin
                mHold[i] = mHold[i] - 1;
            end else begin
                mPeak[i] = imax(mCur[i], mPeak[i] - PEAK_FALL);
            end
        end
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < NUM_BARS; i++) begin
            mCur[i] = 0;
            mPeak[i] = 0;
            mHold[i] = 0;
        end
    endfunction

    task automatic checkPublished(input string tag);
        for (int i = 0; i < NUM_BARS; i++) begin
            checkOutput($sformatf("%s.heights[%0d]", tag, i), int'(bus.heights[i]), mCur[i]);
            checkOutput($sformatf("%s.peaks[%0d]", tag, i), int'(bus.peaks[i]), mPeak[i]);
            checkOutput($sformatf("%s.peak_ge_height[%0d]", tag, i),
                        int'(bus.peaks[i] >= bus.heights[i]), 1);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        modelReset();
    endtask

    // Drives one frame and checks busy/out_valid timing and the published result.
    // A non-zero dupAt re-asserts raw_valid so it is sampled at edge T+dupAt.
    task automatic applyStimulus(input string tag, input int vals [NUM_BARS], input int dupAt);
        int badBusy = 0;
        int badValid = 0;
        for (int i = 0; i < NUM_BARS; i++)
            bus.raw_heights[i] = height_t'(vals[i]);
        bus.raw_valid = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= NUM_BARS + 1; k++) begin
            if (!bus.busy) badBusy++;
            if (bus.out_valid) badValid++;
            if (k == dupAt) begin
                for (int i = 0; i < NUM_BARS; i++)
                    bus.raw_heights[i] = height_t'($urandom_range(0, 511));
                bus.raw_valid = 1'b1;
            end else begin
                bus.raw_valid = 1'b0;
            end
            @(negedge clk);
        end
        modelFrame(vals);
        checkOutput({tag, ".busy_span"}, badBusy, 0);
        checkOutput({tag, ".early_valid"}, badValid, 0);
        checkOutput({tag, ".out_valid"}, int'(bus.out_valid), 1);
        checkOutput({tag, ".busy_done"}, int'(bus.busy), 0);
        checkPublished(tag);
        @(negedge clk);
        checkOutput({tag, ".out_valid_drop"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        int seen;
        bus.raw_valid = 1'b0;
        bus.freeze = 1'b0;
        for (int i = 0; i < NUM_BARS; i++)
            bus.raw_heights[i] = '0;
        @(negedge clk);
        doReset();
        checkOutput("reset.out_valid", int'(bus.out_valid), 0);
        checkOutput("reset.busy", int'(bus.busy), 0);
        checkOutput("reset.overrun", int'(bus.overrun), 0);
        checkPublished("reset");

        for (int i = 0; i < NUM_BARS; i++) frame[i] = 300;
        applyStimulus("attack", frame, 0);
        checkOutput("attack.lit_h", int'(bus.heights[3]), 300);
        checkOutput("attack.lit_p", int'(bus.peaks[3]), 300);

        // Peak hold after a single loud frame followed by silence.
        for (int i = 0; i < NUM_BARS; i++) frame[i] = 0;
        for (int f = 1; f <= 33; f++) begin
            applyStimulus($sformatf("hold%0d", f), frame, 0);
            if (f == 30) checkOutput("hold.lit_300", int'(bus.peaks[0]), 300);
            if (f == 31) checkOutput("hold.lit_298", int'(bus.peaks[0]), 298);
            if (f == 32) checkOutput("hold.lit_296", int'(bus.peaks[0]), 296);
        end

        doReset();
        for (int i = 0; i < NUM_BARS; i++) frame[i] = 200;
        applyStimulus("decay0", frame, 0);
        for (int i = 0; i < NUM_BARS; i++) frame[i] = 0;
        applyStimulus("decay1", frame, 0);
        checkOutput("decay.lit_174", int'(bus.heights[0]), 174);
        applyStimulus("decay2", frame, 0);
        checkOutput("decay.lit_152", int'(bus.heights[0]), 152);
        applyStimulus("decay3", frame, 0);

        doReset();
        for (int i = 0; i < NUM_BARS; i++) frame[i] = 0;
        frame[0] = 5;
        frame[2] = 100;
        applyStimulus("small0", frame, 0);
        frame[0] = 0;
        frame[2] = 95;
        applyStimulus("small1", frame, 0);
        checkOutput("small.lit_4", int'(bus.heights[0]), 4);
        checkOutput("small.lit_0", int'(bus.heights[1]), 0);
        checkOutput("small.lit_95", int'(bus.heights[2]), 95);

        for (int i = 0; i < NUM_BARS; i++) frame[i] = 511;
        applyStimulus("clamp", frame, 0);
        checkOutput("clamp.lit_h", int'(bus.heights[7]), 479);
        checkOutput("clamp.lit_p", int'(bus.peaks[7]), 479);

        checkOutput("overrun.before", int'(bus.overrun), 0);
        for (int i = 0; i < NUM_BARS; i++) frame[i] = $urandom_range(0, 511);
        applyStimulus("overrun", frame, 4);
        checkOutput("overrun.sticky", int'(bus.overrun), 1);
        repeat (20) @(negedge clk);
        checkOutput("overrun.no_second_frame", int'(bus.busy), 0);
        checkPublished("overrun_hold");

        // Freeze: a strobe must not start a frame or disturb the display.
        bus.freeze = 1'b1;
        for (int i = 0; i < NUM_BARS; i++) bus.raw_heights[i] = height_t'(9);
        bus.raw_valid = 1'b1;
        @(negedge clk);
        bus.raw_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < NUM_BARS + 4; k++) begin
            if (bus.busy || bus.out_valid) seen++;
            @(negedge clk);
        end
        bus.freeze = 1'b0;
        checkOutput("freeze.activity", seen, 0);
        checkPublished("freeze");

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < NUM_BARS; i++)
                frame[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 511));
            applyStimulus($sformatf("rand%0d", f), frame, 0);
        end

        // Reset in the middle of a frame aborts it without publishing.
        for (int i = 0; i < NUM_BARS; i++) bus.raw_heights[i] = height_t'(400);
        bus.raw_valid = 1'b1;
        @(negedge clk);
        bus.raw_valid = 1'b0;
        repeat (4) @(negedge clk);
        doReset();
        seen = 0;
        for (int k = 0; k < NUM_BARS + 4; k++) begin
            if (bus.busy || bus.out_valid) seen++;
            @(negedge clk);
        end
        checkOutput("midreset.activity", seen, 0);
        checkOutput("midreset.overrun", int'(bus.overrun), 0);
        checkPublished("midreset");

        for (int i = 0; i < NUM_BARS; i++) frame[i] = $urandom_range(0, 511);
        applyStimulus("after_reset", frame, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
